// File: rtl/ifq_param_if.sv
// Bundle between the instruction fetch queue, program memory and dispatch.
// The queue is the master side. The memory and dispatch environment is the slave side.
interface ifq_param_if #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned AVAIL_W = $clog2(DEPTH * LINE_WORDS + 1);

    logic                    d_valid;
    logic [32*LINE_WORDS-1:0] mem_data;
    logic                    abort;
    logic                    m_rd_en;
    logic [31:0]             mem_addr;
    logic                    jump_branch_valid;
    logic [31:0]             jump_branch_add;
    logic                    d_rd_en;
    logic                    empty;
    logic [31:0]             i_code;
    logic [31:0]             pc_out;
    logic [AVAIL_W-1:0]      words_avail;

    modport master (
        input  d_valid, mem_data, jump_branch_valid, jump_branch_add, d_rd_en,
        output abort, m_rd_en, mem_addr, empty, i_code, pc_out, words_avail
    );

    modport slave (
        output d_valid, mem_data, jump_branch_valid, jump_branch_add, d_rd_en,
        input  abort, m_rd_en, mem_addr, empty, i_code, pc_out, words_avail
    );
endinterface

// File: rtl/ifq_param.sv
// Instruction fetch queue: fetches whole lines from program memory into a circular line buffer.
// It hands out one instruction per cycle with its PC. A redirect can enter partway into a line.
module ifq_param #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    ifq_param_if.master bus
);
    localparam int unsigned OFF_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned AVAIL_W    = $clog2(DEPTH * LINE_WORDS + 1);
    localparam int unsigned LINE_SHIFT = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] LINE_MASK  = 32'(4 * LINE_WORDS - 1);
    localparam logic [31:0] LINE_BYTES = 32'(4 * LINE_WORDS);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {StInit, StFetch, StHold} state_e;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~LINE_MASK;
    endfunction

    function automatic logic [OFF_W-1:0] word_off(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr & LINE_MASK) >> 2;
        return w[OFF_W-1:0];
    endfunction

    state_e               state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OFF_W-1:0]     off_q, off_d;
    logic [CNT_W-1:0]     lines_q, lines_d;
    logic [AVAIL_W-1:0]   avail_q, avail_d;
    logic [32*LINE_WORDS-1:0] line_q [DEPTH];

    logic               is_empty;
    logic               wr;
    logic               rd;
    logic               pop;
    logic [AVAIL_W-1:0] wr_words;
    logic [31:0]        head_word;

    assign is_empty = (avail_q == '0);
    assign wr       = bus.d_valid && (state_q == StFetch) && !bus.jump_branch_valid;
    assign rd       = bus.d_rd_en && !is_empty && !bus.jump_branch_valid;
    assign pop      = rd && (off_q == OFF_W'(LINE_WORDS - 1));
    // An empty queue still holds the entry offset, so a first line only counts words from there.
    assign wr_words = (lines_q == '0) ? AVAIL_W'(LINE_WORDS) - AVAIL_W'(off_q)
                                      : AVAIL_W'(LINE_WORDS);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        off_d      = off_q;
        lines_d    = lines_q;
        avail_d    = avail_q;
        if (bus.jump_branch_valid) begin
            fetch_pc_d = line_base(bus.jump_branch_add);
            off_d      = word_off(bus.jump_branch_add);
            head_d     = '0;
            tail_d     = '0;
            lines_d    = '0;
            avail_d    = '0;
            state_d    = StFetch;
        end else begin
            if (wr) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + LINE_BYTES;
            end
            if (rd) begin
                off_d = pop ? '0 : off_q + OFF_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            lines_d = lines_q + CNT_W'(wr) - CNT_W'(pop);
            avail_d = avail_q + (wr ? wr_words : '0) - AVAIL_W'(rd);
            unique case (state_q)
                StInit:  state_d = StFetch;
                StFetch: if (lines_d == CNT_W'(DEPTH)) state_d = StHold;
                StHold:  if (lines_d < CNT_W'(DEPTH)) state_d = StFetch;
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            fetch_pc_q <= line_base(RESET_PC);
            off_q      <= word_off(RESET_PC);
            head_q     <= '0;
            tail_q     <= '0;
            lines_q    <= '0;
            avail_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            off_q      <= off_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            lines_q    <= lines_d;
            avail_q    <= avail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            line_q[tail_q] <= bus.mem_data;
        end
    end

    assign head_word = line_q[head_q][32 * 32'(off_q) +: 32];

    // Lines are contiguous behind fetch_pc, so the head PC follows from the line count.
    assign bus.pc_out      = fetch_pc_q - (32'(lines_q) << LINE_SHIFT) + (32'(off_q) << 2);
    assign bus.i_code      = is_empty ? NOP : head_word;
    assign bus.empty       = is_empty;
    assign bus.words_avail = avail_q;
    assign bus.m_rd_en     = (state_q == StFetch);
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.abort       = bus.jump_branch_valid && (state_q == StFetch);
endmodule

// File: doc/ifq_param.md
Name: ifq_param

Overview:
- Parametrised instruction fetch queue feeding the dispatch unit of the Tomasulo front end.
- Fetches whole cache lines of LINE_WORDS instructions from program memory and buffers up to DEPTH lines.
- Presents one instruction per cycle, with its PC, to dispatch.
- Compared with the fixed 4-word fetch queue, adds configurable line width and depth, mid-line redirect entry, deterministic empty output and an occupancy count.

Parameters:
- LINE_WORDS, 4: 32-bit instructions per memory line; power of 2, ≥1.
- DEPTH, 4: line slots in the queue; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: fetch start address after reset; may be mid-line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- d_valid  in  1  memory returns the line requested at mem_addr.
- mem_data  in  32*LINE_WORDS  line data; word k is at [32k+31:32k] and belongs to address line_base+4k.
- abort  out  1  one-cycle pulse; memory drops the outstanding request.
- m_rd_en  out  1  level read request; held until d_valid or abort.
- mem_addr  out  32  line-aligned fetch address; stable while m_rd_en=1.
- jump_branch_valid  in  1  redirect from dispatch.
- jump_branch_add  in  32  redirect target; bits [1:0] ignored.
- d_rd_en  in  1  dispatch consumes the head instruction.
- empty  out  1  no valid instruction at head.
- i_code  out  32  head instruction.
- pc_out  out  32  PC of the head instruction.
- words_avail  out  $clog2(DEPTH*LINE_WORDS+1)  valid instructions currently buffered.

Behaviour:
- Storage and pointers
  - Circular line buffer with head/tail line pointers, a head word offset and a lines_used counter.
  - Pointers wrap modulo DEPTH.
- Reset (synchronous, highest priority)
  - Clears all pointers and counters.
  - fetch_pc = RESET_PC with the line-offset bits cleared; entry offset = RESET_PC word bits.
  - Output values in the reset cycle: m_rd_en=0, abort=0, empty=1, words_avail=0, i_code=32'h0000_0013, pc_out=RESET_PC.
  - Reset asserted mid-request discards the request; any d_valid in that cycle is ignored.
- Fetch FSM
  - State FETCH: m_rd_en=1, mem_addr=fetch_pc.
    - On d_valid: write mem_data into the tail slot, tail++, fetch_pc += 4*LINE_WORDS.
    - Stay in FETCH if lines_used after this cycle < DEPTH, otherwise go to HOLD.
  - State HOLD: m_rd_en=0. Return to FETCH in the cycle after a line pop leaves lines_used < DEPTH.
  - First cycle after reset: state = FETCH.
- Entry offset
  - The first line written after reset or redirect starts the head word offset at the entry offset; earlier words of that line are skipped and not counted.
  - Every later line starts at offset 0.
- Read side
  - When !empty: i_code = head slot word at head offset; pc_out = head line base + 4*offset.
  - When empty: i_code = 32'h0000_0013 (NOP); pc_out = next expected PC.
  - empty = (words_avail == 0); combinational from registered state.
  - d_rd_en && !empty: offset++. At offset LINE_WORDS-1, pop the line (head++, offset=0).
  - d_rd_en while empty is ignored.
  - A pop and a d_valid write in the same cycle are both legal; lines_used is unchanged.
- Redirect (jump_branch_valid=1; priority over d_valid and d_rd_en)
  - Flush all lines. d_valid in the same cycle is discarded.
  - fetch_pc = jump_branch_add with the line-offset bits cleared; entry offset = jump_branch_add word bits.
  - abort=1 for this cycle if m_rd_en=1; otherwise abort=0.
  - Next cycle: state FETCH, m_rd_en=1, mem_addr = new line base, empty=1.
  - A redirect is legal in any state, including HOLD and the first cycle after reset.
- words_avail: registered; updated in the same cycle as the pointer updates.

Test Plan:
- Fill (LINE_WORDS=4, DEPTH=4): release reset, memory answers every request after 1 cycle, d_rd_en=0 -> mem_addr sequence 0x00, 0x10, 0x20, 0x30; m_rd_en=0 afterwards; words_avail=16; empty=0.
- Drain: from the full queue, d_rd_en=1 held -> pc_out 0x00, 0x04 … 0x3C in consecutive cycles with matching i_code; m_rd_en reasserts with mem_addr=0x40 the cycle after the 0x0C word is consumed.
- Mid-line redirect: jump_branch_add=0x108 while m_rd_en=1 -> abort=1 for one cycle; next cycle empty=1, mem_addr=0x100; after the line returns, pc_out=0x108, then 0x10C, then 0x110 from the next line; words_avail=2 right after the first line arrives.
- Collision: d_valid and jump_branch_valid in the same cycle -> line discarded; words_avail=0; mem_addr = redirect line base.
- Empty read: d_rd_en=1 with empty=1 -> i_code=0x00000013; pc_out unchanged; words_avail stays 0.
- Reset mid-operation: assert rst while HOLD with 10 words buffered -> the next cycle shows every output at its reset value; the following cycle m_rd_en=1, mem_addr=RESET_PC line base.
